// File: rtl/apb_pkg.sv
// Shared APB completer definitions: bus width defaults, FSM state type and
// the wait-state ceiling the bus protocol checker allows.
package apb_pkg;

  localparam int APB_DATA_W   = 32;
  localparam int APB_ADDR_W   = 32;
  localparam int APB_MAX_WAIT = 5;
  localparam int APB_CNT_W    = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_e;

  function automatic int apb_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Word storage for the APB completer: async-cleared array, one write port,
// one combinational read port.
module apb_slave_regfile #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Every word clears with reset so a dropped transfer can never leave stale data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we_i && (waddr_i == IDX_W'(i))) begin
          mem_q[i] <= wdata_i;
        end
      end
    end
  end

  always_comb begin
    rdata_o = {DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_i == IDX_W'(i)) begin
        rdata_o = mem_q[i];
      end else begin
        rdata_o = rdata_o;
      end
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer over a small word memory: base-relative decode, fixed
// read/write wait states, pslverr on misaligned or out-of-window accesses.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int                DATA_W    = APB_DATA_W,
  parameter int                ADDR_W    = APB_ADDR_W,
  parameter int                DEPTH     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
  parameter int                RD_WAIT   = 1,
  parameter int                WR_WAIT   = 0
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic              pwrite,
  input  logic              psel,
  input  logic              penable,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int                   IDX_W   = apb_idx_w(DEPTH);
  localparam logic [ADDR_W-1:0]    DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [APB_CNT_W-1:0] RD_CNT  = APB_CNT_W'(RD_WAIT);
  localparam logic [APB_CNT_W-1:0] WR_CNT  = APB_CNT_W'(WR_WAIT);

  if ((RD_WAIT < 0) || (RD_WAIT > APB_MAX_WAIT) ||
      (WR_WAIT < 0) || (WR_WAIT > APB_MAX_WAIT)) begin : g_wait_range_check
    $error("apb_slave_mem: RD_WAIT/WR_WAIT must lie in 0..%0d", APB_MAX_WAIT);
  end

  apb_slv_state_e        state_q, state_d;
  logic [APB_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  logic [ADDR_W-1:0]     off_s;
  logic [ADDR_W-1:0]     word_off_s;
  logic                  err_s;
  logic                  pready_s;
  logic                  we_s;
  logic [DATA_W-1:0]     rdata_s;

  // Decode happens once at setup; only the word index and error flag are kept.
  assign off_s      = paddr - BASE_ADDR;
  assign word_off_s = off_s >> 2;
  assign err_s      = (paddr[1:0] != 2'b00) | (paddr < BASE_ADDR) | (word_off_s >= DEPTH_A);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          write_d = pwrite;
          wdata_d = pwdata;
          err_d   = err_s;
          idx_d   = word_off_s[IDX_W-1:0];
          cnt_d   = pwrite ? WR_CNT : RD_CNT;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!psel) begin
          cnt_d   = {APB_CNT_W{1'b0}};
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q == {APB_CNT_W{1'b0}}) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - {{(APB_CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ACCESS;
        end
      end
      default: begin
        cnt_d   = {APB_CNT_W{1'b0}};
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {APB_CNT_W{1'b0}};
      write_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= {IDX_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  assign pready_s = (state_q == ACCESS) & (cnt_q == {APB_CNT_W{1'b0}}) & psel & penable;
  assign we_s     = pready_s & write_q & ~err_q;

  apb_slave_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk_i   (pclk),
    .rst_ni  (rst_n),
    .we_i    (we_s),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (idx_q),
    .rdata_o (rdata_s)
  );

  assign pready  = pready_s;
  assign pslverr = pready_s & err_q;
  assign prdata  = (pready_s & ~write_q & ~err_q) ? rdata_s : {DATA_W{1'b0}};

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: a word model predicts each transfer at
// setup time; results are popped and compared when pready is observed.
module tb_apb_slave_mem;

  localparam int          DEPTH = 16;
  localparam int          RDW   = 1;
  localparam int          WRW   = 0;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] paddr = 32'h0;
  logic [31:0] pwdata = 32'h0;
  logic        pwrite = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 pclk = ~pclk;

  apb_slave_mem #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
    .RD_WAIT(RDW), .WR_WAIT(WRW)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel), .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  function automatic void predict(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t        e;
    logic [31:0] woff;
    woff  = (addr - BASE) >> 2;
    e.wr  = wr;
    e.addr = addr;
    e.err = (addr[1:0] != 2'b00) || (addr < BASE) || (woff >= 32'(DEPTH));
    e.lat = wr ? WRW : RDW;
    e.data = 32'h0;
    if (!e.err) begin
      if (wr) model[int'(woff)] = data;
      else    e.data = model[int'(woff)];
    end
    sb.push_back(e);
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endfunction

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      output logic [31:0] rd, output logic se, output int lat);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    predict(wr, addr, data);
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr = addr ^ 32'h0000_0004;
    pwdata = ~data;
    lat = 0; rd = 32'h0; se = 1'b0;
    forever begin
      @(negedge pclk);
      if (pready === 1'b1) begin
        rd = prdata; se = pslverr;
        break;
      end
      lat++;
      if (lat > 8) begin
        lat = -1;
        break;
      end
      @(posedge pclk); #1;
    end
  endtask

  task automatic bus_idle();
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0)
      $display("FAIL reset_out: got rdy=%b err=%b rd=%h, want 0/0/0", pready, pslverr, prdata);
    else n_pass++;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    n_checks++;
    if (pready !== 1'b0) $display("FAIL reset_hold: got rdy=%b, want 0", pready);
    else n_pass++;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic se; int lat; exp_t e;
    xfer(1'b1, 32'h08, 32'hDEAD_BEEF, rd, se, lat); e = sb.pop_front();
    n_checks++;
    if (rd !== e.data || se !== e.err || lat != e.lat)
      $display("FAIL wr_08: got rd=%h err=%b lat=%0d, want rd=%h err=%b lat=%0d", rd, se, lat, e.data, e.err, e.lat);
    else n_pass++;
    bus_idle();
    xfer(1'b0, 32'h08, 32'h0, rd, se, lat); e = sb.pop_front();
    n_checks++;
    if (rd !== e.data || se !== e.err || lat != e.lat)
      $display("FAIL rd_08: got rd=%h err=%b lat=%0d, want rd=%h err=%b lat=%0d", rd, se, lat, e.data, e.err, e.lat);
    else n_pass++;
    bus_idle();
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic se; int lat; exp_t e;
    logic [31:0] addrs [6];
    logic        wrs [6];
    addrs = '{32'h04, 32'h40, 32'h06, 32'h04, 32'h3C, 32'h40};
    wrs   = '{1'b1,   1'b0,   1'b0,   1'b0,   1'b1,   1'b1};
    for (int i = 0; i < 6; i++) begin
      xfer(wrs[i], addrs[i], (i == 4) ? 32'h0000_1234 : 32'h5A5A_0000 + 32'(i), rd, se, lat);
      e = sb.pop_front();
      n_checks++;
      if (rd !== e.data || se !== e.err || lat != e.lat)
        $display("FAIL err_seq%0d a=%h: got rd=%h err=%b lat=%0d, want rd=%h err=%b lat=%0d",
                 i, e.addr, rd, se, lat, e.data, e.err, e.lat);
      else n_pass++;
      bus_idle();
    end
    for (int i = 0; i < DEPTH; i++) begin
      xfer(1'b0, 32'(i * 4), 32'h0, rd, se, lat); e = sb.pop_front();
      n_checks++;
      if (rd !== e.data || se !== e.err)
        $display("FAIL sweep a=%h: got rd=%h err=%b, want rd=%h err=%b", e.addr, rd, se, e.data, e.err);
      else n_pass++;
    end
    bus_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic se; int lat; exp_t e;
    for (int i = 0; i < 16; i++) begin
      xfer(i < 8, 32'(i % 8) * 32'h4 + 32'h20 - 32'h20 * 32'(i % 8 / 4),
           32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101), rd, se, lat);
      e = sb.pop_front();
      n_checks++;
      if (rd !== e.data || se !== e.err || lat != e.lat)
        $display("FAIL b2b%0d a=%h: got rd=%h err=%b lat=%0d, want rd=%h err=%b lat=%0d",
                 i, e.addr, rd, se, lat, e.data, e.err, e.lat);
      else n_pass++;
    end
    bus_idle();
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic se; int lat; exp_t e;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1; psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    n_checks++;
    if (pready !== 1'b0) $display("FAIL abort_rd: got rdy=%b, want 0", pready);
    else n_pass++;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hBAD0_BAD0;
    @(posedge pclk); #1; psel = 1'b0;
    @(negedge pclk);
    n_checks++;
    if (pready !== 1'b0) $display("FAIL abort_wr: got rdy=%b, want 0", pready);
    else n_pass++;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'hBAD1_BAD1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      n_checks++;
      if (pready !== 1'b0) $display("FAIL nosetup%0d: got rdy=%b, want 0", i, pready);
      else n_pass++;
      @(posedge pclk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      xfer(1'b0, 32'h10 + 32'(i * 4), 32'h0, rd, se, lat); e = sb.pop_front();
      n_checks++;
      if (rd !== e.data || se !== e.err || lat != e.lat)
        $display("FAIL post_abort a=%h: got rd=%h err=%b lat=%0d, want rd=%h err=%b lat=%0d",
                 e.addr, rd, se, lat, e.data, e.err, e.lat);
      else n_pass++;
      bus_idle();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic se; int lat; exp_t e;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h08;
    @(posedge pclk); #1; penable = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0)
      $display("FAIL rst_rd: got rdy=%b err=%b rd=%h, want 0/0/0", pready, pslverr, prdata);
    else n_pass++;
    clear_model();
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1; rst_n = 1'b1;
    xfer(1'b1, 32'h0C, 32'h1111_2222, rd, se, lat); e = sb.pop_front();
    n_checks++;
    if (rd !== e.data || se !== e.err || lat != e.lat)
      $display("FAIL wr_0c: got rd=%h err=%b lat=%0d, want rd=%h err=%b lat=%0d", rd, se, lat, e.data, e.err, e.lat);
    else n_pass++;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h3333_4444;
    @(posedge pclk); #1; penable = 1'b1;
    #1;
    n_checks++;
    if (pready !== 1'b1) $display("FAIL pre_rst_rdy: got rdy=%b, want 1", pready);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0)
      $display("FAIL rst_wr: got rdy=%b err=%b rd=%h, want 0/0/0", pready, pslverr, prdata);
    else n_pass++;
    clear_model();
    @(posedge pclk); #1; rst_n = 1'b1;
    @(negedge pclk);
    n_checks++;
    if (pready !== 1'b0) $display("FAIL post_rst_rdy: got rdy=%b, want 0", pready);
    else n_pass++;
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      xfer(1'b0, 32'(i * 4), 32'h0, rd, se, lat); e = sb.pop_front();
      n_checks++;
      if (rd !== e.data || se !== e.err || lat != e.lat)
        $display("FAIL rst_clear a=%h: got rd=%h err=%b lat=%0d, want rd=%h err=%b lat=%0d",
                 e.addr, rd, se, lat, e.data, e.err, e.lat);
      else n_pass++;
    end
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    test_reset();
    test_write_read();
    test_errors();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
